pipe_stage_elastic: RTL
=======================

# pipe_stage_elastic

Parametrised pipeline stage register for the RV32 core. It is the successor to the fixed-width ID/EXE register: the same stage-to-stage latch, but with a valid/ready handshake and an optional 2-entry skid buffer. It also takes a per-bit flush mask and carries built-in cycle, transfer and bubble counters for CSR reporting. It is instantiated between any two pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB).

## Interface
- DATA_W, 160, width of the payload data bundle (operands, imm, pc, addresses, funct).
- CTRL_W, 16, width of the control bundle (RegWrite, MemRead, MemWrite, Branch, …).
- KILL_MASK, {CTRL_W{1'b1}}, control bits forced to 0 on flush; unmasked bits keep their value.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 64, width of each performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- hold  in  1  global stall (im_stall | dm_stall); freezes the stage.
- flush  in  1  kill the stage contents (control hazard).
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  registered payload.
- out_ctrl  out  CTRL_W  registered control.
- cnt_clear  in  1  synchronous zero of all counters.
- cnt_cycle  out  CNT_W  cycles since reset/clear.
- cnt_xfer  out  CNT_W  completed output handshakes.
- cnt_bubble  out  CNT_W  cycles with out_ready=1, out_valid=0, hold=0.

## Operation
- Reset: out_valid=0, out_data=0, out_ctrl=0, skid entry empty and zeroed, all counters 0. in_ready=1 when SKID=1; in_ready=~hold when SKID=0.
- Accept: in_valid & in_ready & ~hold. Emit: out_valid & out_ready & ~hold.
- Priority per cycle: hold > flush > normal transfer.
- Hold:
  - All state is frozen, including skid, data, ctrl and valid.
  - No handshake completes on either side. in_ready is still driven, but is ignored because hold=1.
  - cnt_cycle still increments.
- Flush (hold=0):
  - out_valid and skid valid are cleared.
  - out_ctrl and skid ctrl become ctrl & ~KILL_MASK. Data is retained, not cleared.
  - A beat presented on the input in the same cycle is dropped.
  - A flush that arrives during hold has no effect. The hazard unit keeps flush asserted until hold drops.
- SKID=1 state machine, over main and skid entries:
  - EMPTY: accept → FULL1, with the beat in main.
  - FULL1: accept & emit → FULL1, main replaced. Accept & ~emit → FULL2, beat into skid and in_ready drops next cycle. Emit only → EMPTY.
  - FULL2: emit → FULL1, skid moves to main and in_ready rises next cycle. No accept is possible in FULL2.
  - Flush from any state → EMPTY.
- SKID=0: in_ready = ~hold & (~out_valid | out_ready). The single register behaves as FULL1/EMPTY.
- Ordering: beats leave strictly in acceptance order. No beat is ever duplicated or lost except by flush.
- Counters:
  - Each counter wraps modulo 2^CNT_W.
  - cnt_clear takes priority over increment in the same cycle, so the counter reads 0 in the next cycle.
  - A cycle that counts a flush is never counted as an xfer.

## Timing
- Latency: 1 cycle from accept to out_valid, in EMPTY.
- Throughput: 1 beat/cycle while out_ready=1.
- SKID=1: in_ready is a flop with no combinational path from out_ready. After out_ready falls it takes exactly one cycle to drop; the beat accepted in that cycle lands in skid.
- Flush effect: out_valid=0 in the cycle after flush is sampled.
- Counters update on the edge; values are visible in the next cycle.

## Structure
- Package pipe_pkg:
  - typedef perf_cnt_t (logic [CNT_W-1:0] default 64).
  - Constant CTRL_KILL_ALL.
  - ID/EXE ctrl field-position localparams (REGWRITE_B, MEMREAD_B, MEMWRITE_B, BRANCH_LSB), used to build KILL_MASK.
- Sub-module pipe_perf_cnt: the three counters with clear/wrap logic. The skid/handshake FSM lives in pipe_stage_elastic.

## Test plan
- Reset mid-stream: assert reset with FULL2 → next cycle out_valid=0, out_ctrl=0, cnt_*=0, in_ready=1.
- Streaming, SKID=1, out_ready=1: 8 beats, data 0x1..0x8 → out_data 0x1..0x8 on consecutive cycles, 1-cycle latency, cnt_xfer=8.
- Back-pressure: drop out_ready for 3 cycles while driving 0xA,0xB,0xC:
  - 0xB lands in skid and in_ready=0 for those cycles.
  - On release, output is 0xA,0xB,0xC in order, with nothing lost.
- Flush, KILL_MASK=16'h00FF, ctrl=16'hABCD, FULL2: flush=1 with in_valid=1 → out_valid=0, out_ctrl=16'hAB00, incoming beat dropped, state EMPTY.
- Hold vs flush: hold=1 and flush=1 together → contents unchanged, out_valid stays 1, cnt_cycle increments, cnt_xfer does not.
- Counter wrap and clear, CNT_W=4: 16 transfers → cnt_xfer=0. cnt_clear during an xfer → 0 next cycle. Idle with out_ready=1 for 5 cycles → cnt_bubble=5.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the elastic pipeline stage.
//   perf_cnt_t      : default-width performance counter word.
//   CTRL_KILL_ALL   : flush mask that clears every control bit.
//   *_B / BRANCH_LSB: ID/EXE control field positions, used to build a
//                     flush mask that only kills side-effecting bits.
//   ST_*            : skid/handshake FSM state encodings.
package pipe_pkg;

  localparam int CNT_W_DEF  = 64;
  localparam int CTRL_W_DEF = 16;

  typedef logic [CNT_W_DEF-1:0] perf_cnt_t;

  localparam logic [CTRL_W_DEF-1:0] CTRL_KILL_ALL = '1;

  // ID/EXE control bundle layout
  localparam int REGWRITE_B = 0;
  localparam int MEMREAD_B  = 1;
  localparam int MEMWRITE_B = 2;
  localparam int BRANCH_LSB = 3;
  localparam int BRANCH_W   = 2;

  // Kill only the bits that would cause an architectural side effect.
  function automatic logic [CTRL_W_DEF-1:0] kill_mask_idex();
    logic [CTRL_W_DEF-1:0] m;
    m = '0;
    m[REGWRITE_B] = 1'b1;
    m[MEMREAD_B]  = 1'b1;
    m[MEMWRITE_B] = 1'b1;
    m[BRANCH_LSB +: BRANCH_W] = '1;
    return m;
  endfunction

  // FSM over main/skid entries: EMPTY (nothing), FULL1 (main), FULL2 (main+skid)
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL1 = 2'd1;
  localparam logic [1:0] ST_FULL2 = 2'd2;

endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: cycle / transfer / bubble counters for CSR reporting.
//   clk, reset (async, active-low)
//   clear      : synchronous zero of all counters, wins over increment
//   xfer_inc   : count one completed output handshake
//   bubble_inc : count one idle downstream cycle
//   cnt_cycle, cnt_xfer, cnt_bubble : counter values (wrap modulo 2^CNT_W)
module pipe_perf_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             xfer_inc,
  input  logic             bubble_inc,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_xfer,
  output logic [CNT_W-1:0] cnt_bubble
);

  logic [CNT_W-1:0] cycle_q,  cycle_d;
  logic [CNT_W-1:0] xfer_q,   xfer_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  always_comb begin
    cycle_d  = cycle_q + CNT_W'(1);
    xfer_d   = xfer_q + CNT_W'(xfer_inc);
    bubble_d = bubble_q + CNT_W'(bubble_inc);
    if (clear) begin
      cycle_d  = '0;
      xfer_d   = '0;
      bubble_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q  <= '0;
      xfer_q   <= '0;
      bubble_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      xfer_q   <= xfer_d;
      bubble_q <= bubble_d;
    end
  end

  assign cnt_cycle  = cycle_q;
  assign cnt_xfer   = xfer_q;
  assign cnt_bubble = bubble_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: pipeline stage register with valid/ready handshake,
// optional 2-entry skid buffer, per-bit control flush and perf counters.
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_data/in_ctrl      : upstream side
//   out_valid/out_ready/out_data/out_ctrl  : downstream side (registered)
//   hold  : global stall, freezes all stage state
//   flush : kill contents (control bits in KILL_MASK cleared, data kept)
//   cnt_clear, cnt_cycle, cnt_xfer, cnt_bubble : performance counters
//
// Handshake: a beat moves when valid & ready & ~hold on that side in the same
// cycle; valid never depends on ready, and hold overrides both sides.
// The FSM state is held in state_q (ST_EMPTY/ST_FULL1/ST_FULL2).
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 160,
  parameter int                CTRL_W    = 16,
  parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}},
  parameter int                SKID      = 1,
  parameter int                CNT_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              hold,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  cnt_cycle,
  output logic [CNT_W-1:0]  cnt_xfer,
  output logic [CNT_W-1:0]  cnt_bubble
);

  logic [1:0]        state_q,     state_d;
  logic              in_ready_q,  in_ready_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              accept, emit;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;

  // With a skid entry in_ready is a pure flop (no path from out_ready);
  // without it the single register frees up combinationally on emit.
  assign in_ready = (SKID != 0) ? in_ready_q
                                : (~hold & (~out_valid | out_ready));

  assign accept = in_valid & in_ready & ~hold;
  assign emit   = out_valid & out_ready & ~hold;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (!hold) begin
      if (flush) begin
        // Any beat accepted this cycle is simply not stored.
        state_d     = ST_EMPTY;
        main_ctrl_d = main_ctrl_q & ~KILL_MASK;
        skid_ctrl_d = skid_ctrl_q & ~KILL_MASK;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              state_d     = ST_FULL1;
              main_data_d = in_data;
              main_ctrl_d = in_ctrl;
            end
          end
          ST_FULL1: begin
            if (accept && emit) begin
              main_data_d = in_data;
              main_ctrl_d = in_ctrl;
            end else if (accept) begin
              // Only reachable with SKID=1: in_ready was still high as
              // out_ready fell, so park the beat behind main.
              state_d     = ST_FULL2;
              skid_data_d = in_data;
              skid_ctrl_d = in_ctrl;
            end else if (emit) begin
              state_d = ST_EMPTY;
            end
          end
          ST_FULL2: begin
            if (emit) begin
              state_d     = ST_FULL1;
              main_data_d = skid_data_q;
              main_ctrl_d = skid_ctrl_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end
    in_ready_d = (state_d != ST_FULL2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .xfer_inc   (emit & ~flush),
    .bubble_inc (out_ready & ~out_valid & ~hold),
    .cnt_cycle  (cnt_cycle),
    .cnt_xfer   (cnt_xfer),
    .cnt_bubble (cnt_bubble)
  );

endmodule
